data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
// - Responder end of the MEM-stage memory handshake: answers load/store requests from the MEM stage with wait states.
// - Returns read data and drives ready; ready low freezes IF/ID/EXE/MEM (freeze = ~ready).
// - Holds the word-addressed data array behind it and sits between the MEM stage and the data store.
// PARAMETERS
// - ADDR_LEN     32    request address width (byte address)
// - DATA_LEN     32    data word width
// - DEPTH_WORDS  64    words in array, power of 2
// - BASE_ADDR    1024  byte address mapped to word 0
// - WAIT_CYCLES  4     extra busy cycles per access, 0..255
// PORTS
// - clk         in   1              rising-edge clock
// - rst         in   1              asynchronous, active-low reset
// - mem_r_en    in   1              load request, held until ready=1
// - mem_w_en    in   1              store request, held until ready=1
// - addr        in   ADDR_LEN       byte address, word aligned
// - wdata       in   DATA_LEN       store data (Val_Rm)
// - rdata       out  DATA_LEN       load data, registered
// - ready       out  1              1 = idle or access completing this cycle
// BEHAVIOUR
// - req = mem_r_en | mem_w_en. Word index = ((addr - BASE_ADDR) >> 2) mod DEPTH_WORDS; addr[1:0] ignored; out-of-range wraps.
// - Reset (rst=0, async): state=IDLE, cnt=0, rdata=0, captured addr/data/op cleared, ready forced 1. Array contents not cleared.
// - FSM IDLE -> WAIT -> DONE -> IDLE.
// - IDLE: ready = ~req (combinational, so the freeze asserts in the request's first cycle).
//   - On req: capture index, wdata and op (write wins if both enables are high; rdata is then unchanged).
//   - Go to WAIT with cnt=WAIT_CYCLES, or straight to DONE if WAIT_CYCLES=0.
// - WAIT: ready=0. cnt decrements each cycle; when cnt==1, go to DONE next edge.
// - DONE: ready=1 for exactly one cycle.
//   - Store: array[idx] <= captured wdata at the DONE edge.
//   - Load: rdata is loaded with array[idx] on entry to DONE and is valid during DONE.
//   - Next state is IDLE unconditionally; a new request is seen there.
// - Latency: request first seen in cycle t; ready=0 in cycles t..t+WAIT_CYCLES; ready=1 in t+WAIT_CYCLES+1 (stall = WAIT_CYCLES+1 cycles).
// - rdata holds its value until the next load completes (WB samples it after the MEM register).
// - Request dropped in WAIT: abort to IDLE, no array write, rdata unchanged.
// - Request dropped in DONE: the access still completes.
// - addr/wdata changing in WAIT: ignored, captured values are used.
// - Back-to-back: the store completes in DONE, then a load to the same word in the following IDLE->DONE returns the new data.
// - Reset mid-access: abort immediately, no write, return to IDLE.
// CONFIGURATION
// - MEM_RESP_STATS_EN defined: adds outputs rd_count[15:0], wr_count[15:0], stall_count[15:0].
//   - rd_count/wr_count: +1 per completed load/store (DONE).
//   - stall_count: +1 per cycle with req & ~ready.
//   - All saturate at 16'hFFFF and reset to 0.
// - MEM_RESP_STATS_EN undefined: these ports and counters do not exist; behaviour otherwise identical.
// TESTING (WAIT_CYCLES=4, BASE_ADDR=1024 unless noted)
// - Store wdata=32'hDEADBEEF to addr 1028, hold until ready -> ready low 5 cycles, high in cycle 6; word 1 = DEADBEEF.
// - Load addr 1028 after that store -> rdata=32'hDEADBEEF in the DONE cycle; rdata held while idle afterwards.
// - WAIT_CYCLES=0: load request -> ready low exactly 1 cycle, then high with data.
// - Address 1024+4*64 -> aliases to word 0; both enables high -> treated as a store, rdata unchanged.
// - Assert rst=0 in the 2nd WAIT cycle of a store -> ready=1 and rdata=0 at once; target word keeps its old value.
// - With MEM_RESP_STATS_EN: 3 loads + 2 stores -> rd_count=3, wr_count=2, stall_count=25.

Source files
------------

// File: rtl/data_mem_responder.sv
// Responder side of the MEM-stage load/store handshake with a word-addressed data array and fixed wait states.
// Optional MEM_RESP_STATS_EN adds saturating load/store/stall counters.
module data_mem_responder #(
  parameter int ADDR_LEN    = 32,
  parameter int DATA_LEN    = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_r_en,
  input  logic                mem_w_en,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic [DATA_LEN-1:0] wdata,
  output logic [DATA_LEN-1:0] rdata,
  output logic                ready
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [15:0]         rd_count,
  output logic [15:0]         wr_count,
  output logic [15:0]         stall_count
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_LEN-1:0]   wdata_q, wdata_d;
  logic [DATA_LEN-1:0]   rdata_q, rdata_d;
  logic                  wr_q, wr_d;
  logic                  mem_we;
  logic                  ready_fsm;
  logic [DATA_LEN-1:0]   mem_q [DEPTH_WORDS];

  logic                  req;
  logic [ADDR_LEN-1:0]   addr_off;
  logic [IDX_W-1:0]      req_idx;
  logic                  unused_addr_bits;

  assign req      = mem_r_en | mem_w_en;
  assign addr_off = addr - ADDR_LEN'(BASE_ADDR);
  // Out-of-range addresses wrap by simply dropping the upper offset bits.
  assign req_idx  = addr_off[IDX_W+1:2];
  assign unused_addr_bits = ^{addr_off[ADDR_LEN-1:IDX_W+2], addr_off[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d   = req_idx;
          wdata_d = wdata;
          wr_d    = mem_w_en;
          if (WAIT_CYCLES == 0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 8'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q <= 8'd1) begin
          state_d = S_DONE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        mem_we  = wr_q;
      end
      default: state_d = S_IDLE;
    endcase
    // Load data is fetched on the edge that enters DONE so it is valid throughout DONE.
    if (state_d == S_DONE && state_q != S_DONE && !wr_d) begin
      rdata_d = mem_q[idx_d];
    end
  end

  always_comb begin
    ready_fsm = 1'b0;
    case (state_q)
      S_IDLE:  ready_fsm = ~req;
      S_DONE:  ready_fsm = 1'b1;
      default: ready_fsm = 1'b0;
    endcase
  end

  // Reset releases the pipeline freeze immediately, even with a request still asserted.
  assign ready = ready_fsm | ~rst;
  assign rdata = rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

`ifdef MEM_RESP_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (state_q == S_DONE && !wr_q && rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
    if (state_q == S_DONE &&  wr_q && wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
    if (req && !ready_fsm && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q    <= 16'd0;
      wr_cnt_q    <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign rd_count    = rd_cnt_q;
  assign wr_count    = wr_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a WAIT_CYCLES=4 instance (u0) and a WAIT_CYCLES=0 instance (u1).
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        re0 = 1'b0, we0 = 1'b0, re1 = 1'b0, we1 = 1'b0;
  logic [31:0] ad0 = '0, wd0 = '0, ad1 = '0, wd1 = '0;
  logic [31:0] rd0, rd1;
  logic        rdy0, rdy1;
`ifdef MEM_RESP_STATS_EN
  logic [15:0] rc0, wc0, sc0, rc1, wc1, sc1;
`endif

  always #5 clk = ~clk;

  data_mem_responder #(.WAIT_CYCLES(4)) u0 (
    .clk(clk), .rst(rst), .mem_r_en(re0), .mem_w_en(we0), .addr(ad0), .wdata(wd0),
    .rdata(rd0), .ready(rdy0)
`ifdef MEM_RESP_STATS_EN
    , .rd_count(rc0), .wr_count(wc0), .stall_count(sc0)
`endif
  );

  data_mem_responder #(.WAIT_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .mem_r_en(re1), .mem_w_en(we1), .addr(ad1), .wdata(wd1),
    .rdata(rd1), .ready(rdy1)
`ifdef MEM_RESP_STATS_EN
    , .rd_count(rc1), .wr_count(wc1), .stall_count(sc1)
`endif
  );

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] hold [2];
  logic [31:0] sb_q [$];
  vec_t        vecs [10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int s, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (s == 0) begin re0 = r; we0 = w; ad0 = a; wd0 = d; end
    else        begin re1 = r; we1 = w; ad1 = a; wd1 = d; end
  endtask

  // One request held until ready; chg_at > 0 scrambles addr/wdata after that many stalled cycles.
  task automatic access(input int s, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input int exp_low,
                        input int chg_at, input string nm);
    int low = 0;
    bit done = 0;
    logic [31:0] exp;
    @(posedge clk); #1;
    drive(s, r, w, a, d);
    if (r && !w) sb_q.push_back(exp_rd);
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if ((s == 0) ? rdy0 : rdy1) done = 1;
      else begin
        low++;
        if (low == chg_at) drive(s, r, w, a + 32'd4, ~d);
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL %s timeout got ready=0 want ready=1", nm);
    end
    check({nm, " stall"}, 32'(low), 32'(exp_low));
    if (r && !w) begin
      exp = sb_q.pop_front();
      hold[s] = exp;
    end
    check({nm, " rdata_done"}, (s == 0) ? rd0 : rd1, hold[s]);
    @(posedge clk); #1;
    drive(s, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check({nm, " ready_idle"}, 32'((s == 0) ? rdy0 : rdy1), 32'd1);
    check({nm, " rdata_hold"}, (s == 0) ? rd0 : rd1, hold[s]);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 32'd1024, 32'hA5A50001, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'd1280, 32'h0,        32'hA5A50001};
    vecs[4] = '{1'b1, 1'b1, 32'd1028, 32'h11112222, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'h11112222};
    vecs[6] = '{1'b0, 1'b1, 32'd1276, 32'hCAFEF00D, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 32'd1276, 32'h0,        32'hCAFEF00D};
    vecs[8] = '{1'b1, 1'b0, 32'd1031, 32'h0,        32'h11112222};
    vecs[9] = '{1'b1, 1'b0, 32'd1020, 32'h0,        32'hCAFEF00D};
    hold[0] = 32'h0;
    hold[1] = 32'h0;

    // Reset state, with a request asserted on u0 to show ready is forced high.
    re0 = 1'b1;
    #12;
    check("rst ready0", 32'(rdy0), 32'd1);
    check("rst ready1", 32'(rdy1), 32'd1);
    check("rst rdata0", rd0, 32'h0);
    check("rst rdata1", rd1, 32'h0);
    re0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      access(0, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_rd, 5, 0, $sformatf("vec%0d", i));
    end
`ifdef MEM_RESP_STATS_EN
    check("stats rd_count", 32'(rc0), 32'd6);
    check("stats wr_count", 32'(wc0), 32'd4);
    check("stats stall_count", 32'(sc0), 32'd50);
`endif

    // Zero wait states: one stall cycle per access.
    access(1, 1'b0, 1'b1, 32'd1032, 32'h12345678, 32'h0, 1, 0, "w0 store");
    access(1, 1'b1, 1'b0, 32'd1032, 32'h0, 32'h12345678, 1, 0, "w0 load");

    // addr/wdata changed during WAIT must not affect the captured access.
    access(0, 1'b0, 1'b1, 32'd1032, 32'h01020304, 32'h0, 5, 2, "chg store");
    access(0, 1'b1, 1'b0, 32'd1032, 32'h0, 32'h01020304, 5, 0, "chg load");

    // Request dropped in WAIT aborts: no write, rdata unchanged.
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 32'd1028, 32'h0BAD0BAD);
    @(posedge clk); @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); @(negedge clk);
    check("abort ready", 32'(rdy0), 32'd1);
    check("abort rdata", rd0, hold[0]);
    access(0, 1'b1, 1'b0, 32'd1028, 32'h0, 32'h11112222, 5, 0, "abort load");

    // Reset in the second WAIT cycle of a store: immediate release, no write.
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 32'd1028, 32'h99999999);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst ready", 32'(rdy0), 32'd1);
    check("midrst rdata", rd0, 32'h0);
    hold[0] = 32'h0;
    hold[1] = 32'h0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    access(0, 1'b1, 1'b0, 32'd1028, 32'h0, 32'h11112222, 5, 0, "midrst load");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
